ps2_kbd_rx: RTL and testbench



---
 rtl/ps2_kbd_rx.sv | 235 +++++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Purpose  : PS/2 device-to-host receiver. Deserialises start/8 data/odd
//            parity/stop frames, decodes E0 (extended) and F0 (break)
//            prefixes into an 11-bit key event word, and exports raw byte
//            and error strobes for diagnostics.
// Options  : define PS2_KBD_RX_FILTER_EN to deglitch ps2_clk with a
//            FILTER_LEN-sample agreement counter before edge detection.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
  parameter int TIMEOUT_CYCLES = 64000,
  parameter int FILTER_LEN     = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        rx_err,
  output logic        busy
);

  localparam int          TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Synchroniser chain; idle-high lines so reset to 1
  logic clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;

  // Two-flop synchronisers for both asynchronous PS/2 lines
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  logic clk_eff;

`ifdef PS2_KBD_RX_FILTER_EN
  localparam int             FW      = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]  FLT_MAX = FW'(FILTER_LEN - 1);

  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;

  // Deglitcher: flip only after FILTER_LEN consecutive disagreeing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FLT_MAX) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // Filter state registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign clk_eff = filt_q;
`else
  assign clk_eff = clk_s2_q;
`endif

  logic            clk_prev_q, clk_prev_d;
  logic            fall;
  state_t          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            par_q, par_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            ext_q, ext_d, brk_q, brk_d;
  logic [10:0]     key_q, key_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d, err_q, err_d, busy_q, busy_d;
  logic            frame_ok, frame_bad, timeout;

  assign clk_prev_d = clk_eff;
  assign fall       = clk_prev_q & ~clk_eff;

  // Frame FSM next-state, timeout counter and prefix decode
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_d     = key_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;

    // Counter clears on every edge and while idle; saturates otherwise
    if (state_q == ST_IDLE || fall) begin
      to_d = '0;
    end else if (to_q != TO_MAX) begin
      to_d = to_q + 1'b1;
    end else begin
      to_d = to_q;
    end
    // A coincident falling edge takes priority over the timeout
    timeout = (state_q != ST_IDLE) && !fall && (to_q == TO_MAX);

    case (state_q)
      ST_IDLE: begin
        if (fall && !data_s2_q) begin
          state_d  = ST_DATA;
          bitcnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shreg_d  = {data_s2_q, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = data_s2_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (data_s2_q && ((^shreg_q) ^ par_q)) frame_ok = 1'b1;
          else                                   frame_bad = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end

    if (frame_ok) begin
      byte_d  = shreg_q;
      valid_d = 1'b1;
      if (shreg_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shreg_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        key_d = {~key_q[10], ~brk_q, ext_q, shreg_q};
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end

    if (frame_bad) begin
      err_d = 1'b1;
      ext_d = 1'b0;
      brk_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Receiver state and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      shreg_q    <= 8'h00;
      par_q      <= 1'b0;
      to_q       <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      key_q      <= 11'h000;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      to_q       <= to_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      key_q      <= key_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign ps2_key  = key_q;
  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;
  assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx
// Purpose  : Self-checking bench for ps2_kbd_rx. Drives directed and random
//            PS/2 frames and compares against a prefix-decoding key model.
//            Glitch checks are included when PS2_KBD_RX_FILTER_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

  localparam int TO    = 200;
  localparam int FLEN  = 8;
  localparam int HALF  = 20;

  logic        clk_sys  = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_valid, rx_err, busy;

  ps2_kbd_rx #(.TIMEOUT_CYCLES(TO), .FILTER_LEN(FLEN)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .ps2_key (ps2_key),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk_sys) cyc++;

  // Monotonic pulse counters sampled away from the active edge
  int valid_cnt = 0, err_cnt = 0, busy_cnt = 0, last_err_cyc = 0;
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (rx_valid) valid_cnt++;
      if (rx_err) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: prefix flags plus last event word
  logic [10:0] m_key  = '0;
  logic [7:0]  m_byte = '0;
  logic        m_ext  = 1'b0;
  logic        m_brk  = 1'b0;

  task automatic model_good(input logic [7:0] b);
    m_byte = b;
    if (b == 8'hE0)      m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_clear();
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  int fall_cyc = 0;

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF/2) @(negedge clk_sys);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk  = 1'b1;
    repeat (HALF/2) @(negedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
  endtask

  task automatic frame_check(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    int v0, e0;
    logic good;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(b, bad_par, bad_stop);
    repeat (HALF) @(negedge clk_sys);
    good = !bad_par && !bad_stop;
    if (good) model_good(b);
    else      model_clear();
    chk("valid_pulses", valid_cnt - v0, good ? 1 : 0);
    chk("err_pulses",   err_cnt - e0,   good ? 0 : 1);
    chk("rx_byte",      rx_byte, m_byte);
    chk("ps2_key",      ps2_key, m_key);
    chk("busy_idle",    busy, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0, e0, b0, lat, r;
    logic [7:0] rb;

    repeat (4) @(negedge clk_sys);
    chk("rst_key",  ps2_key, 0);
    chk("rst_byte", rx_byte, 0);
    chk("rst_flags", {rx_valid, rx_err, busy}, 0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk_sys);

    // Directed sequences with literal expectations
    frame_check(8'h1C, 1'b0, 1'b0);
    chk("a_key", ps2_key, 11'h61C);
    frame_check(8'hF0, 1'b0, 1'b0);
    frame_check(8'h1C, 1'b0, 1'b0);
    chk("brk_key", ps2_key, 11'h01C);
    frame_check(8'hE0, 1'b0, 1'b0);
    frame_check(8'hF0, 1'b0, 1'b0);
    frame_check(8'h75, 1'b0, 1'b0);
    chk("ext_brk_key", ps2_key, 11'h575);
    // Parity error after a prefix, then a clean frame
    frame_check(8'hE0, 1'b0, 1'b0);
    frame_check(8'h1C, 1'b1, 1'b0);
    frame_check(8'h1C, 1'b0, 1'b0);
    chk("post_err_key", ps2_key, 11'h21C);
    frame_check(8'h33, 1'b0, 1'b1);

    // Timeout mid-frame with a pending prefix that must be dropped
    frame_check(8'hF0, 1'b0, 1'b0);
    v0 = valid_cnt;
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    chk("to_busy_mid", busy, 1);
    repeat (TO + 40) @(negedge clk_sys);
    model_clear();
    lat = last_err_cyc - fall_cyc;
    chk("to_err_pulses", err_cnt - e0, 1);
    chk("to_valid", valid_cnt - v0, 0);
    chk("to_busy", busy, 0);
    chk("to_latency_ok", (lat >= TO && lat <= TO + FLEN + 8) ? 1 : 0, 1);
    frame_check(8'h2B, 1'b0, 1'b0);

    // Randomised traffic including prefixes and framing errors
    for (int k = 0; k < 24; k++) begin
      r  = $urandom_range(0, 9);
      rb = 8'($urandom);
      case (r)
        0, 1:    frame_check(8'hE0, 1'b0, 1'b0);
        2, 3:    frame_check(8'hF0, 1'b0, 1'b0);
        4:       frame_check(rb, 1'b1, 1'b0);
        5:       frame_check(rb, 1'b0, 1'b1);
        default: frame_check(rb, 1'b0, 1'b0);
      endcase
    end

    // Reset mid-frame: outputs clear asynchronously, partial frame lost
    frame_check(8'hE0, 1'b0, 1'b0);
    frame_check(8'h5A, 1'b0, 1'b0);
    v0 = valid_cnt;
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_key",  ps2_key, 0);
    chk("mid_rst_byte", rx_byte, 0);
    chk("mid_rst_flags", {rx_valid, rx_err, busy}, 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    m_key  = '0;
    m_byte = '0;
    model_clear();
    repeat (TO + 40) @(negedge clk_sys);
    chk("mid_rst_valid", valid_cnt - v0, 0);
    chk("mid_rst_err",   err_cnt - e0, 0);
    frame_check(8'h1C, 1'b0, 1'b0);
    chk("after_rst_key", ps2_key, 11'h61C);

`ifdef PS2_KBD_RX_FILTER_EN
    // Short low glitches on ps2_clk must not start a frame
    b0 = busy_cnt;
    e0 = err_cnt;
    ps2_data = 1'b0;
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge clk_sys);
      ps2_clk = 1'b1;
      repeat (12) @(negedge clk_sys);
    end
    ps2_data = 1'b1;
    repeat (20) @(negedge clk_sys);
    chk("glitch_busy", busy_cnt - b0, 0);
    chk("glitch_err",  err_cnt - e0, 0);
    frame_check(8'h1C, 1'b0, 1'b0);
`else
    b0 = busy_cnt;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
